// File: rtl/add_serial_arb_if.sv
// rtl/add_serial_arb_if.sv - request/operand/result bundle for the shared serial adder
interface add_serial_arb_if;
  logic [1:0] req;
  logic [7:0] a0;
  logic [7:0] b0;
  logic [7:0] a1;
  logic [7:0] b1;
  logic [1:0] grant;
  logic       busy;
  logic       done_vld;
  logic       done_id;
  logic [7:0] out;
  logic       cout;

  // Requester side: drives requests and operands, observes results.
  modport master (
    output req, a0, b0, a1, b1,
    input  grant, busy, done_vld, done_id, out, cout
  );

  // Adder side: arbitrates, computes, reports.
  modport slave (
    input  req, a0, b0, a1, b1,
    output grant, busy, done_vld, done_id, out, cout
  );
endinterface

// File: rtl/add_serial_arb.sv
// rtl/add_serial_arb.sv - two-requester arbiter sharing one bit-serial 8-bit adder
module add_serial_arb #(
  parameter int FAIR = 1
) (
  input  logic             clk,
  input  logic             rst,
  add_serial_arb_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic FAIR_EN = (FAIR != 0);

  logic [1:0] state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       carry_q, carry_d;
  logic [2:0] count_q, count_d;
  logic       ptr_q, ptr_d;
  logic [1:0] grant_q, grant_d;
  logic       done_vld_q, done_vld_d;
  logic       done_id_q, done_id_d;
  logic [7:0] out_q, out_d;
  logic       cout_q, cout_d;

  logic win;
  logic sum_bit;
  logic carry_nxt;

  // Winner select: a lone request always wins; a tie goes to the requester
  // that did not win last time (round-robin) or to requester 0 (fixed).
  always_comb begin
    win = bus.req[1];
    if (bus.req[0] && bus.req[1]) begin
      win = FAIR_EN ? ~ptr_q : 1'b0;
    end
  end

  // One full-adder slice, fed by the LSBs of the shifting operand registers.
  always_comb begin
    sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  end

  // Next-state logic: capture in IDLE, eight shift/add steps in ADD, one
  // result-valid cycle in DONE. Results are left untouched until next capture.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    count_d    = count_q;
    ptr_d      = ptr_q;
    grant_d    = 2'b00;
    done_vld_d = 1'b0;
    done_id_d  = done_id_q;
    out_d      = out_q;
    cout_d     = cout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req != 2'b00) begin
          a_d       = win ? bus.a1 : bus.a0;
          b_d       = win ? bus.b1 : bus.b0;
          carry_d   = 1'b0;
          count_d   = 3'd0;
          out_d     = 8'h00;
          cout_d    = 1'b0;
          grant_d   = win ? 2'b10 : 2'b01;
          done_id_d = win;
          ptr_d     = win;
          state_d   = S_ADD;
        end
      end
      S_ADD: begin
        out_d   = {sum_bit, out_q[7:1]};
        carry_d = carry_nxt;
        a_d     = {1'b0, a_q[7:1]};
        b_d     = {1'b0, b_q[7:1]};
        count_d = count_q + 3'd1;
        if (count_q == 3'd7) begin
          state_d    = S_DONE;
          done_vld_d = 1'b1;
          cout_d     = carry_nxt;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight and biases the
  // first tie toward requester 0 by parking ptr on requester 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      carry_q    <= 1'b0;
      count_q    <= 3'd0;
      ptr_q      <= 1'b1;
      grant_q    <= 2'b00;
      done_vld_q <= 1'b0;
      done_id_q  <= 1'b0;
      out_q      <= 8'h00;
      cout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      count_q    <= count_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      done_vld_q <= done_vld_d;
      done_id_q  <= done_id_d;
      out_q      <= out_d;
      cout_q     <= cout_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done_vld = done_vld_q;
  assign bus.done_id  = done_id_q;
  assign bus.out      = out_q;
  assign bus.cout     = cout_q;

endmodule
